uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx transmitter among NUM_REQ requesters.
- Arbitrates pending requests (round-robin by default) and latches the winner's data.
- Issues a one-cycle start pulse with stable data to the transmitter, then blocks new grants until the frame and the inter-frame gap have elapsed.
- Sits between the host-side producers and the UART TX datapath; all on one clock domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 7, payload width per frame, matching the transmitter data input.
- FRAME_LEN, 8, clock cycles the transmitter needs to shift one frame.
- GAP_CYCLES, 1, idle cycles inserted after each frame (0 allowed).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- req  input  NUM_REQ  per-requester request level; held until its ack.
- data_in  input  NUM_REQ*DATA_W  packed payloads; requester i owns bits [i*DATA_W +: DATA_W].
- ack  output  NUM_REQ  one-hot, one-cycle pulse: that requester's payload was taken.
- tx_start  output  1  one-cycle start pulse to the transmitter.
- tx_data  output  DATA_W  payload to the transmitter; stable for the whole frame.
- tx_busy  output  1  high whenever state != IDLE.
- grant_id  output  $clog2(NUM_REQ)  index of the most recent grant.

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - Reset is synchronous and active-low on rst_n: sampled on posedge clk only.
- Reset values:
  - state=IDLE.
  - ack=0, tx_start=0, tx_data=0, tx_busy=0, grant_id=0.
  - rr_ptr=0, counter=0.
- Reset mid-operation (any state): the next edge returns to IDLE with all reset values.
  - No further tx_start is issued for the aborted frame.
  - The abandoned requester's req stays pending; it is re-arbitrated normally.
- IDLE:
  - Each cycle, if any req bit is set, select the winner.
  - Round-robin search order: rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - On that edge: latch the winner's data_in into tx_data, set grant_id=winner, set rr_ptr=(winner+1) mod NUM_REQ, go to LAUNCH.
  - If no req is set, stay in IDLE; outputs hold.
- LAUNCH (exactly 1 cycle):
  - tx_start=1.
  - ack[grant_id]=1; all other ack bits are 0.
  - Next state is WAIT with counter=0.
- WAIT:
  - tx_start=0, ack=0.
  - Lasts FRAME_LEN cycles; counter increments each cycle.
  - At counter==FRAME_LEN-1, go to GAP, or to IDLE if GAP_CYCLES==0.
- GAP:
  - Lasts GAP_CYCLES cycles, then IDLE.
- tx_data holds its latched value from LAUNCH until the next grant (it never changes outside IDLE->LAUNCH).
- Frame-to-frame spacing:
  - Minimum tx_start period under continuous demand is 2+FRAME_LEN+GAP_CYCLES cycles.
  - With defaults this is 11.
- Requester rules:
  - req and data_in must be stable from assertion until ack.
  - Requester deasserts req in the cycle after ack, or it is treated as a new request.
  - A req that drops before grant is simply never served; no ack is produced.
  - req changes during LAUNCH/WAIT/GAP are ignored until IDLE.
- Simultaneous requests: resolved only by rr_ptr order; exactly one grant per IDLE cycle.
- Width rule: counter width is $clog2(max(FRAME_LEN,GAP_CYCLES)+1); it saturates never, it is reset on every state entry.

Optional Feature:
- Macro: UART_TX_ARB_FIXED_PRIORITY_EN.
- Defined: fixed priority; the lowest-index asserted req always wins, and rr_ptr is not implemented.
- Undefined: round-robin as specified above.
- All other timing is identical in both builds.

Test Plan:
- Single request: after reset, req=4'b0100, data for requester 2 = 7'h55.
  - Expect one edge later: tx_start=1, ack=4'b0100, tx_data=7'h55, grant_id=2.
  - Then tx_busy=1 for 10 cycles total; tx_data stays 7'h55 throughout.
- Continuous demand: req=4'b1111 held, payloads 7'h11/22/33/44 for requesters 0..3.
  - Expect grants 0,1,2,3,0 with tx_data 11,22,33,44,11.
  - tx_start pulses exactly 11 cycles apart.
- Simultaneous requests: last grant was 1 (rr_ptr=2); req=4'b1010 asserted together.
  - Expect grant 3 first, then 1 on the next frame.
- Reset in WAIT: rst_n=0 for one cycle at WAIT counter=4.
  - Expect at the next edge: tx_busy=0, tx_start=0, tx_data=0, grant_id=0.
  - The still-held req[3] is then granted with grant_id=3 via pointer 0 search.
- Dropped request: req[1] pulsed for 3 cycles during WAIT and cleared before IDLE.
  - Expect no ack[1] and no tx_start after the frame ends.
- Fixed-priority build with UART_TX_ARB_FIXED_PRIORITY_EN defined: req[0] and req[3] both held.
  - Expect requester 0 granted every frame; ack[3] never asserts.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ requesters: the start pulse and ack come one edge after the grant, then new grants wait 1+FRAME_LEN+GAP_CYCLES cycles.
// Define UART_TX_ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration; the default build is round-robin.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 7,
  parameter int FRAME_LEN  = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  data_in,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       tx_start,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int IW      = $clog2(NUM_REQ);
  localparam int CNT_MAX = (FRAME_LEN > GAP_CYCLES) ? FRAME_LEN : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  state_t            state;
  logic [CW-1:0]     counter;
  logic              found;
  logic [IW-1:0]     winner;
  logic [DATA_W-1:0] win_data;
  logic [DATA_W-1:0] pay [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) pay[i] = data_in[i*DATA_W +: DATA_W];
  end

`ifdef UART_TX_ARB_FIXED_PRIORITY_EN
  // Descending scan so the lowest asserted index is the last one written.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    win_data = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        found    = 1'b1;
        winner   = IW'(i);
        win_data = pay[i];
      end
    end
  end
`else
  localparam int IW1 = IW + 1;
  logic [IW-1:0]  rr_ptr;
  logic [IW1-1:0] sum;
  logic [IW-1:0]  idx;

  always_comb begin
    found    = 1'b0;
    winner   = '0;
    win_data = '0;
    sum      = '0;
    idx      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr} + IW1'(i);
      if (sum >= IW1'(NUM_REQ)) sum = sum - IW1'(NUM_REQ);
      idx = sum[IW-1:0];
      if (!found && req[idx]) begin
        found    = 1'b1;
        winner   = idx;
        win_data = pay[idx];
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ack      <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      tx_busy  <= 1'b0;
      grant_id <= '0;
      counter  <= '0;
`ifndef UART_TX_ARB_FIXED_PRIORITY_EN
      rr_ptr   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            state    <= S_LAUNCH;
            tx_data  <= win_data;
            grant_id <= winner;
            tx_start <= 1'b1;
            ack      <= NUM_REQ'(1) << winner;
            tx_busy  <= 1'b1;
            counter  <= '0;
`ifndef UART_TX_ARB_FIXED_PRIORITY_EN
            rr_ptr   <= (winner == IW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
`endif
          end
        end
        S_LAUNCH: begin
          state    <= S_WAIT;
          tx_start <= 1'b0;
          ack      <= '0;
          counter  <= '0;
        end
        S_WAIT: begin
          if (counter == FRAME_LAST) begin
            counter <= '0;
            if (GAP_CYCLES == 0) begin
              state   <= S_IDLE;
              tx_busy <= 1'b0;
            end else begin
              state <= S_GAP;
            end
          end else begin
            counter <= counter + 1'b1;
          end
        end
        S_GAP: begin
          if (counter == GAP_LAST) begin
            state   <= S_IDLE;
            tx_busy <= 1'b0;
            counter <= '0;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scenarios plus randomized requesters checked cycle by cycle against a grant/elapsed-time model.
module tb_uart_tx_arbiter;

  localparam int N        = 4;
  localparam int DW       = 7;
  localparam int FL       = 8;
  localparam int GAP      = 1;
  localparam int BUSY_LEN = 1 + FL + GAP;
  localparam int PERIOD   = 2 + FL + GAP;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*DW-1:0] data_in = '0;
  logic [N-1:0]  ack;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic          tx_busy;
  logic [1:0]    grant_id;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: a grant opens a busy window; m_since counts edges since that grant.
  int            m_since = BUSY_LEN;
  int            m_ptr   = 0;
  int            m_gid   = 0;
  logic [DW-1:0] m_data  = '0;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .FRAME_LEN(FL), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .ack(ack),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, bad=%0d", bad);
    $fatal(1);
  end

  task automatic model_edge();
    int w;
    int j;
    logic [N-1:0] r;
    r = req;
    w = -1;
    if (!rst_n) begin
      m_since = BUSY_LEN; m_ptr = 0; m_data = '0; m_gid = 0;
    end else if (m_since < BUSY_LEN) begin
      m_since++;
    end else if (r != '0) begin
`ifdef UART_TX_ARB_FIXED_PRIORITY_EN
      for (int k = N - 1; k >= 0; k--) if (r[k]) w = k;
`else
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (w < 0 && r[j]) w = j;
      end
      m_ptr = (w + 1) % N;
`endif
      m_gid   = w;
      m_data  = data_in[w*DW +: DW];
      m_since = 0;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; data_in = '0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; data_in = '1;
    step(); step();
    total++;
    if (tx_busy !== 1'b0 || tx_start !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl: busy=%b start=%b, required 0 0", tx_busy, tx_start);
    end
    total++;
    if (ack !== 4'b0000 || tx_data !== 7'h00 || grant_id !== 2'd0) begin
      bad++; $display("FAIL reset_vals: ack=%b data=%h gid=%0d, required 0000 00 0", ack, tx_data, grant_id);
    end
    req = '0; data_in = '0; rst_n = 1'b1;
    step(); step();
    total++;
    if (tx_busy !== 1'b0 || tx_start !== 1'b0) begin
      bad++; $display("FAIL idle_no_req: busy=%b start=%b, required 0 0", tx_busy, tx_start);
    end
  endtask

  task automatic test_single();
    int busy_cnt;
    bit data_ok;
    do_reset();
    req = 4'b0100; data_in[2*DW +: DW] = 7'h55;
    step();
    total++;
    if (tx_start !== 1'b1 || ack !== 4'b0100) begin
      bad++; $display("FAIL single_launch: start=%b ack=%b, required 1 0100", tx_start, ack);
    end
    total++;
    if (tx_data !== 7'h55 || grant_id !== 2'd2) begin
      bad++; $display("FAIL single_grant: data=%h gid=%0d, required 55 2", tx_data, grant_id);
    end
    req = '0;
    busy_cnt = (tx_busy === 1'b1) ? 1 : 0;
    data_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (tx_busy === 1'b1) begin
        busy_cnt++;
        if (tx_data !== 7'h55) data_ok = 1'b0;
      end
      if (tx_start !== 1'b0) data_ok = 1'b0;
    end
    total++;
    if (busy_cnt != BUSY_LEN) begin
      bad++; $display("FAIL single_busy_len: got %0d cycles, required %0d", busy_cnt, BUSY_LEN);
    end
    total++;
    if (!data_ok) begin
      bad++; $display("FAIL single_data_stable: data/start disturbed during frame, required 55 and no restart");
    end
    total++;
    if (tx_data !== 7'h55 || grant_id !== 2'd2) begin
      bad++; $display("FAIL single_idle_hold: data=%h gid=%0d, required 55 2", tx_data, grant_id);
    end
  endtask

  task automatic test_continuous();
    int n;
    int last;
    int gids [5];
    logic [DW-1:0] dats [5];
    logic [DW-1:0] exp_d [4];
    exp_d = '{7'h11, 7'h22, 7'h33, 7'h44};
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < N; i++) data_in[i*DW +: DW] = exp_d[i];
    n = 0; last = 0;
    for (int c = 0; c < 80 && n < 5; c++) begin
      step();
      if (tx_start === 1'b1) begin
        gids[n] = int'(grant_id);
        dats[n] = tx_data;
        if (n > 0) begin
          total++;
          if (cyc - last != PERIOD) begin
            bad++; $display("FAIL cont_period: %0d cycles between starts, required %0d", cyc - last, PERIOD);
          end
        end
        last = cyc;
        n++;
      end
    end
    total++;
    if (n != 5) begin
      bad++; $display("FAIL cont_timeout: %0d starts seen, required 5", n);
    end
    for (int k = 0; k < n; k++) begin
      total++;
      if (gids[k] != k % N || dats[k] !== exp_d[k % N]) begin
        bad++; $display("FAIL cont_grant%0d: gid=%0d data=%h, required %0d %h", k, gids[k], dats[k], k % N, exp_d[k % N]);
      end
    end
    req = '0;
  endtask

  task automatic test_simultaneous();
    int n;
    int gids [2];
    do_reset();
    req = 4'b0010; data_in[1*DW +: DW] = 7'h2A;
    step();
    total++;
    if (tx_start !== 1'b1 || grant_id !== 2'd1) begin
      bad++; $display("FAIL simul_setup: start=%b gid=%0d, required 1 1", tx_start, grant_id);
    end
    req = 4'b1010; data_in[3*DW +: DW] = 7'h3C;
    n = 0;
    for (int c = 0; c < 40 && n < 2; c++) begin
      step();
      if (tx_start === 1'b1) begin
        gids[n] = int'(grant_id);
        n++;
        req = req & ~ack;
      end
    end
    total++;
    if (n != 2) begin
      bad++; $display("FAIL simul_timeout: %0d grants seen, required 2", n);
    end else begin
      total++;
      if (gids[0] != 3 || gids[1] != 1) begin
        bad++; $display("FAIL simul_order: grants %0d,%0d, required 3,1", gids[0], gids[1]);
      end
    end
    req = '0;
  endtask

  task automatic test_reset_wait();
    do_reset();
    req = 4'b1000; data_in[3*DW +: DW] = 7'h4B;
    step();
    for (int c = 0; c < 5; c++) step();
    total++;
    if (tx_busy !== 1'b1 || tx_start !== 1'b0 || ack !== 4'b0000) begin
      bad++; $display("FAIL rstwait_pre: busy=%b start=%b ack=%b, required 1 0 0000", tx_busy, tx_start, ack);
    end
    rst_n = 1'b0;
    step();
    total++;
    if (tx_busy !== 1'b0 || tx_start !== 1'b0 || tx_data !== 7'h00 || grant_id !== 2'd0) begin
      bad++; $display("FAIL rstwait_reset: busy=%b start=%b data=%h gid=%0d, required 0 0 00 0",
                      tx_busy, tx_start, tx_data, grant_id);
    end
    rst_n = 1'b1;
    step();
    total++;
    if (tx_start !== 1'b1 || grant_id !== 2'd3 || tx_data !== 7'h4B || ack !== 4'b1000) begin
      bad++; $display("FAIL rstwait_regrant: start=%b gid=%0d data=%h ack=%b, required 1 3 4b 1000",
                      tx_start, grant_id, tx_data, ack);
    end
    req = '0;
  endtask

  task automatic test_dropped();
    int ack1;
    int starts;
    do_reset();
    req = 4'b0001; data_in[0 +: DW] = 7'h01;
    step();
    req = '0;
    ack1 = 0; starts = 0;
    step(); step();
    req[1] = 1'b1; data_in[1*DW +: DW] = 7'h5A;
    for (int c = 0; c < 3; c++) begin
      step();
      if (ack[1] === 1'b1) ack1++;
      if (tx_start === 1'b1) starts++;
    end
    req[1] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (ack[1] === 1'b1) ack1++;
      if (tx_start === 1'b1) starts++;
    end
    total++;
    if (ack1 != 0 || starts != 0) begin
      bad++; $display("FAIL dropped_req: ack1=%0d starts=%0d, required 0 0", ack1, starts);
    end
    total++;
    if (tx_busy !== 1'b0) begin
      bad++; $display("FAIL dropped_idle: busy=%b, required 0", tx_busy);
    end
  endtask

`ifdef UART_TX_ARB_FIXED_PRIORITY_EN
  task automatic test_fixed_priority();
    int frames;
    int ack3;
    do_reset();
    req = 4'b1001; data_in[0 +: DW] = 7'h0F; data_in[3*DW +: DW] = 7'h70;
    frames = 0; ack3 = 0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (ack[3] === 1'b1) ack3++;
      if (tx_start === 1'b1) begin
        frames++;
        total++;
        if (grant_id !== 2'd0 || tx_data !== 7'h0F) begin
          bad++; $display("FAIL fixed_grant: gid=%0d data=%h, required 0 0f", grant_id, tx_data);
        end
      end
    end
    total++;
    if (frames < 4 || ack3 != 0) begin
      bad++; $display("FAIL fixed_starve: frames=%0d ack3=%0d, required >=4 and 0", frames, ack3);
    end
    req = '0;
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] e_ack;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && ack[i]) begin
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          data_in[i*DW +: DW] = DW'($urandom);
        end
      end
      rst_n = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      step();
      e_ack = (m_since == 0) ? (N'(1) << m_gid) : '0;
      total++;
      if (tx_start !== (m_since == 0)) begin
        bad++; $display("FAIL rand_start cyc %0d: got %b, required %b", cyc, tx_start, m_since == 0);
      end
      total++;
      if (ack !== e_ack) begin
        bad++; $display("FAIL rand_ack cyc %0d: got %b, required %b", cyc, ack, e_ack);
      end
      total++;
      if (tx_busy !== (m_since < BUSY_LEN)) begin
        bad++; $display("FAIL rand_busy cyc %0d: got %b, required %b", cyc, tx_busy, m_since < BUSY_LEN);
      end
      total++;
      if (tx_data !== m_data || grant_id !== 2'(m_gid)) begin
        bad++; $display("FAIL rand_data cyc %0d: data=%h gid=%0d, required %h %0d", cyc, tx_data, grant_id, m_data, m_gid);
      end
    end
    rst_n = 1'b1;
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
`ifdef UART_TX_ARB_FIXED_PRIORITY_EN
    test_fixed_priority();
`else
    test_continuous();
    test_simultaneous();
`endif
    test_reset_wait();
    test_dropped();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
